// File: rtl/alu_pipe.sv
// alu_pipe: single-stage valid/ready ALU with registered result, carry-out and chained carry.
// Optional zero/ovf flag outputs are enabled by defining ALU_PIPE_FLAGS_EN.
`timescale 1ns/1ps
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    cin,
  input  logic [2:0]              control,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] d,
`ifdef ALU_PIPE_FLAGS_EN
  output logic                    zero,
  output logic                    ovf,
`endif
  output logic                    cout
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_ADC = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_PAS = 3'b111;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             cout_q, cout_d;
  logic             carry_q, carry_d;
  logic             accept_s;
  logic             arith_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] res_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             cout_res_s;
`ifdef ALU_PIPE_FLAGS_EN
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             ovf_res_s;
`endif

  assign in_ready = !out_valid_q || out_ready;
  assign accept_s = in_valid && in_ready;

  // Result datapath: arithmetic is done one bit wider so the top bit is the carry-out.
  always_comb begin
    sum_s      = {(WIDTH+1){1'b0}};
    res_s      = {WIDTH{1'b0}};
    b_eff_s    = b;
    cout_res_s = 1'b0;
    arith_s    = 1'b0;
    case (control)
      OP_AND: res_s = a & b;
      OP_OR:  res_s = a | b;
      OP_XOR: res_s = a ^ b;
      OP_ADD: begin
        sum_s   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        arith_s = 1'b1;
      end
      OP_SUB: begin
        b_eff_s = ~b;
        sum_s   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        arith_s = 1'b1;
      end
      OP_ADC: begin
        sum_s   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_q};
        arith_s = 1'b1;
      end
      OP_SLT: res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_PAS: res_s = a;
      default: res_s = {WIDTH{1'b0}};
    endcase
    if (arith_s) begin
      res_s      = sum_s[WIDTH-1:0];
      cout_res_s = sum_s[WIDTH];
    end else begin
      cout_res_s = 1'b0;
    end
  end

`ifdef ALU_PIPE_FLAGS_EN
  // Signed overflow: operands of equal sign producing a result of the other sign.
  always_comb begin
    if (arith_s) begin
      ovf_res_s = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (res_s[WIDTH-1] != a[WIDTH-1]);
    end else begin
      ovf_res_s = 1'b0;
    end
  end
`endif

  // Next-state: load on accept, drop valid on a drain with no accept, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    d_d         = d_q;
    cout_d      = cout_q;
    carry_d     = carry_q;
`ifdef ALU_PIPE_FLAGS_EN
    zero_d      = zero_q;
    ovf_d       = ovf_q;
`endif
    if (accept_s) begin
      out_valid_d = 1'b1;
      d_d         = res_s;
      cout_d      = cout_res_s;
`ifdef ALU_PIPE_FLAGS_EN
      zero_d      = (res_s == {WIDTH{1'b0}});
      ovf_d       = ovf_res_s;
`endif
      if (arith_s) begin
        carry_d = cout_res_s;
      end else begin
        carry_d = carry_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      d_q         <= {WIDTH{1'b0}};
      cout_q      <= 1'b0;
      carry_q     <= 1'b0;
`ifdef ALU_PIPE_FLAGS_EN
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      cout_q      <= cout_d;
      carry_q     <= carry_d;
`ifdef ALU_PIPE_FLAGS_EN
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign cout      = cout_q;
`ifdef ALU_PIPE_FLAGS_EN
  assign zero      = zero_q;
  assign ovf       = ovf_q;
`endif

endmodule
